decode_stage: RTL



---
 rtl/decode_stage.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with valid/ready handshake and optional skid buffer
//
// Decodes one RV32I (optionally +M) instruction per accepted transfer and presents
// the control bundle one cycle later, in order, at full throughput.
//
// Parameters
//   M_EXT : 1 = MUL/DIV/REM decoded, 0 = those encodings flagged illegal
//   SKID  : 1 = main + skid register, registered o_ready
//           0 = single register, combinational o_ready
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid/o_ready       fetch-side handshake, i_inst/i_pc payload
//   i_flush               drop everything held and offered this cycle
//   o_valid/i_ready       execute-side handshake
//   o_pc, o_rs1/2, o_rd   bundle address and register fields
//   o_rs1_used/o_rs2_used operands actually read
//   o_imm                 sign-extended immediate
//   o_alu_*               ALU operation select and operand muxing
//   o_funct3              raw funct3
//   o_cond_br/o_jump      control-flow flags
//   o_mem_we              store
//   o_wb_sel/o_wb_we      writeback source (one-hot) and enable
//   o_illegal             illegal encoding

module decode_stage #(
    parameter int M_EXT = 1,
    parameter int SKID  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_rs1_used,
    output logic        o_rs2_used,
    output logic [31:0] o_imm,
    output logic [4:0]  o_alu_op_sel,
    output logic        o_alu_sub,
    output logic        o_alu_arith,
    output logic        o_alu_a_sel,
    output logic        o_alu_b_sel,
    output logic [2:0]  o_funct3,
    output logic        o_cond_br,
    output logic        o_jump,
    output logic        o_mem_we,
    output logic [2:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_illegal
);

    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_ARIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_ENV    = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [4:0] SEL_ADD   = 5'b00001;
    localparam logic [4:0] SEL_SLT   = 5'b00010;
    localparam logic [4:0] SEL_BOOL  = 5'b00100;
    localparam logic [4:0] SEL_SHIFT = 5'b01000;
    localparam logic [4:0] SEL_MDIV  = 5'b10000;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] imm;
        logic [4:0]  alu_op_sel;
        logic        alu_sub;
        logic        alu_arith;
        logic        alu_a_sel;
        logic        alu_b_sel;
        logic [2:0]  funct3;
        logic        cond_br;
        logic        jump;
        logic        mem_we;
        logic [2:0]  wb_sel;
        logic        wb_we;
        logic        illegal;
    } bundle_t;

    // ALU unit chosen by funct3 for register and immediate arithmetic
    function automatic logic [4:0] f3_to_sel(input logic [2:0] f3);
        case (f3)
            3'b000:         f3_to_sel = SEL_ADD;
            3'b010, 3'b011: f3_to_sel = SEL_SLT;
            3'b001, 3'b101: f3_to_sel = SEL_SHIFT;
            default:        f3_to_sel = SEL_BOOL;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_arith, is_arimm, is_load, is_store, is_branch;
    logic       is_jal, is_jalr, is_auipc, is_lui;
    logic       is_muldiv;
    logic       illegal;
    logic       legal;
    bundle_t    dec;

    assign opcode    = i_inst[6:0];
    assign f3        = i_inst[14:12];
    assign f7        = i_inst[31:25];
    assign is_arith  = (opcode == OP_ARITH);
    assign is_arimm  = (opcode == OP_ARIMM);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_lui    = (opcode == OP_LUI);
    assign is_muldiv = is_arith && (f7 == 7'b0000001) && (M_EXT != 0);

    always_comb begin
        illegal = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
        case (opcode)
            OP_ARITH: begin
                if (!((f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                      is_muldiv)) begin
                    illegal = 1'b1;
                end
            end
            OP_ARIMM: begin
                if ((f3 == 3'b001) && (f7 != 7'b0000000)) begin
                    illegal = 1'b1;
                end
                if ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000)) begin
                    illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 >= 3'b011) begin
                    illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if ((f3 == 3'b010) || (f3 == 3'b011)) begin
                    illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (f3 != 3'b000) begin
                    illegal = 1'b1;
                end
            end
            OP_JAL, OP_AUIPC, OP_LUI, OP_ENV, OP_FENCE: begin
            end
            default: illegal = 1'b1;
        endcase
    end

    assign legal = !illegal;

    always_comb begin
        dec          = '0;
        dec.pc       = i_pc;
        dec.rs1      = is_lui ? 5'd0 : i_inst[19:15];
        dec.rs2      = i_inst[24:20];
        dec.rd       = i_inst[11:7];
        dec.funct3   = f3;
        dec.illegal  = illegal;
        dec.rs1_used = is_arith | is_arimm | is_load | is_store | is_branch | is_jalr;
        dec.rs2_used = is_arith | is_store | is_branch;

        case (opcode)
            OP_ARIMM, OP_LOAD, OP_JALR, OP_ENV, OP_FENCE:
                dec.imm = {{20{i_inst[31]}}, i_inst[31:20]};
            OP_STORE:
                dec.imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            OP_BRANCH:
                dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            OP_AUIPC, OP_LUI:
                dec.imm = {i_inst[31:12], 12'd0};
            OP_JAL:
                dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default:
                dec.imm = 32'd0;
        endcase

        // Everything other than register/immediate arithmetic uses the adder
        // (addresses, PC targets, LUI as x0 + imm); illegal words too.
        dec.alu_op_sel = SEL_ADD;
        if (legal && (is_arith || is_arimm)) begin
            dec.alu_op_sel = is_muldiv ? SEL_MDIV : f3_to_sel(f3);
        end
        dec.alu_sub   = legal && is_arith && (f3 == 3'b000) && f7[5];
        dec.alu_arith = legal && (is_arith || is_arimm) && (f3 == 3'b101) && f7[5];
        dec.alu_a_sel = is_branch | is_jal | is_auipc;
        dec.alu_b_sel = !is_arith;

        dec.cond_br = legal && is_branch;
        dec.jump    = legal && (is_jal || is_jalr);
        dec.mem_we  = legal && is_store;

        dec.wb_sel = 3'b000;
        if (legal) begin
            if (is_arith || is_arimm || is_auipc || is_lui) begin
                dec.wb_sel = 3'b001;
            end else if (is_load) begin
                dec.wb_sel = 3'b010;
            end else if (is_jal || is_jalr) begin
                dec.wb_sel = 3'b100;
            end
        end
        dec.wb_we = |dec.wb_sel;
    end

    // Output (main) register and optional skid register
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept;
    logic    drain;

    assign o_ready = (SKID != 0) ? !skid_valid_q : (!main_valid_q || i_ready);
    assign accept  = i_valid && o_ready;
    assign drain   = main_valid_q && i_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (drain) begin
                // o_ready is low whenever the skid is full, so accept and a
                // full skid never coincide here.
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    main_d = dec;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (main_valid_q) begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end else begin
                    main_d       = dec;
                    main_valid_d = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else if (drain) begin
                main_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign o_valid      = main_valid_q;
    assign o_pc         = main_q.pc;
    assign o_rs1        = main_q.rs1;
    assign o_rs2        = main_q.rs2;
    assign o_rd         = main_q.rd;
    assign o_rs1_used   = main_q.rs1_used;
    assign o_rs2_used   = main_q.rs2_used;
    assign o_imm        = main_q.imm;
    assign o_alu_op_sel = main_q.alu_op_sel;
    assign o_alu_sub    = main_q.alu_sub;
    assign o_alu_arith  = main_q.alu_arith;
    assign o_alu_a_sel  = main_q.alu_a_sel;
    assign o_alu_b_sel  = main_q.alu_b_sel;
    assign o_funct3     = main_q.funct3;
    assign o_cond_br    = main_q.cond_br;
    assign o_jump       = main_q.jump;
    assign o_mem_we     = main_q.mem_we;
    assign o_wb_sel     = main_q.wb_sel;
    assign o_wb_we      = main_q.wb_we;
    assign o_illegal    = main_q.illegal;

endmodule
